vissue_ctrl: RTL and testbench
==============================

// Module: vissue_ctrl
// PURPOSE
// Vector issue controller sitting directly upstream of vregfile_wrapper. Accepts decoded vector
// instructions from the scalar pipeline and holds vtype/vl state written by vset*. Drives the VRF
// request/operand/LMUL interface and holds the request until the VRF reports vector_done.
// Stalls the pipeline while a vector operation is in flight.
// PARAMETERS
// VLEN       128  vector register width in bits
// ELEN       32   element width per VRF beat
// AddrWidth  5    vector register address width
// PORTS
// clk_i             in   1          clock
// rst_i             in   1          async reset, active-high
// valid_i           in   1          decoded vector instruction present
// ready_o           out  1          controller can accept (IDLE)
// is_vset_i         in   1          instruction is vset*
// vset_lmul_i       in   3          requested vlmul_e (RVV encoding)
// vset_avl_i        in   32         application vector length
// num_operands_i    in   2          source operands to read (0..3)
// we_i              in   1          operation writes vd
// raddr_a_i/b_i     in   AddrWidth  vs1/vs2 base register
// waddr_i           in   AddrWidth  vd base register
// vrf_req_o         out  1          request to VRF (req_i)
// vrf_we_o          out  1          write enable to VRF
// vrf_raddr_a_o/b_o out  AddrWidth  latched source addresses
// vrf_waddr_o       out  AddrWidth  latched destination address
// vrf_num_ops_o     out  2          latched operand count
// vrf_lmul_o        out  3          current vtype LMUL
// vrf_done_i        in   1          vector_done from VRF
// vl_o              out  32         current vl
// vill_o            out  1          vtype illegal
// illegal_o         out  1          1-cycle pulse: instruction rejected
// stall_o           out  1          = ~ready_o
// BEHAVIOUR
// - Reset: state IDLE; ready_o=1; vrf_req_o=0, vrf_we_o=0, addrs=0, vrf_num_ops_o=0;
//   vrf_lmul_o=VLMUL_1; vl_o=0; vill_o=1; illegal_o=0.
// - Accept on valid_i && ready_o. States: IDLE, BUSY.
// - vset (accepted in IDLE, stays IDLE): COUNT=VLEN/ELEN; VLMAX = COUNT<<L for LMUL 1/2/4/8
//   (L=0..3), COUNT>>k for F2/F4/F8 (k=1..3), 32-bit unsigned. Reserved encoding 3'b100
//   or VLMAX==0: vill_o=1, vl_o=0, vrf_lmul_o unchanged. Else vill_o=0,
//   vl_o=min(avl,VLMAX), vrf_lmul_o=vset_lmul_i. Updates visible the next cycle.
// - Vector op in IDLE: rejected (illegal_o pulse next cycle, stay IDLE) if vill_o=1, or
//   LMUL>1 and any used register (vd if we_i; vs1 if ops>=1; vs2 if ops>=2) is not a multiple
//   of LMUL. Otherwise latch addrs/we/ops; next cycle vrf_req_o=1 and state BUSY.
// - BUSY: all vrf_* outputs stable, ready_o=0. vrf_req_o stays high across every register-group
//   iteration (the VRF only continues a group while req is high).
// - BUSY && vrf_done_i: next cycle vrf_req_o=0, vrf_we_o=0, state IDLE, ready_o=1. The VRF is
//   therefore IDLE with req low and cannot restart spuriously.
// - vrf_done_i in IDLE ignored. valid_i in BUSY ignored (ready_o=0; upstream holds).
// - Back-to-back: the op after a done is accepted earliest in the cycle ready_o returns to 1.
// - Reset mid-op: vrf_req_o drops asynchronously; the VRF (own reset) must be reset together.
// CONFIGURATION
// VISSUE_PERF_CNT_EN defined: adds outputs perf_busy_cyc_o[31:0] (+1 each BUSY cycle) and
//   perf_ops_o[31:0] (+1 per done in BUSY); both wrap at 2^32; reset 0.
// Not defined: ports absent, no counters; all other behaviour identical.
// TESTING
// - vset LMUL_2 (3'b001), avl=5 -> next cycle vl_o=5 (VLMAX 8), vill_o=0, vrf_lmul_o=3'b001.
// - vset F8 (3'b101), avl=3 -> VLMAX 0: vill_o=1, vl_o=0; then vector op -> illegal_o pulse,
//   vrf_req_o stays 0.
// - LMUL_4, op vd=4,vs1=8,vs2=12,ops=2,we=1 -> req high, held through 4 groups until done;
//   req low the cycle after done, ready_o=1.
// - LMUL_2, vs1=3 -> illegal_o 1 cycle, no request, state IDLE.
// - Spurious vrf_done_i in IDLE; valid_i during BUSY -> no state change, latched addrs unchanged.
// - rst_i asserted while BUSY -> vrf_req_o=0 immediately; counters (if VISSUE_PERF_CNT_EN) =0.

Source files
------------

// File: rtl/vissue_ctrl.sv
// Vector issue controller: holds vtype/vl from vset*, issues one op at a time to the VRF.
// Optional macro VISSUE_PERF_CNT_EN adds busy-cycle and completed-op counters.
module vissue_ctrl #(
  parameter int VLEN      = 128,
  parameter int ELEN      = 32,
  parameter int AddrWidth = 5
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 valid_i,
  output logic                 ready_o,
  input  logic                 is_vset_i,
  input  logic [2:0]           vset_lmul_i,
  input  logic [31:0]          vset_avl_i,
  input  logic [1:0]           num_operands_i,
  input  logic                 we_i,
  input  logic [AddrWidth-1:0] raddr_a_i,
  input  logic [AddrWidth-1:0] raddr_b_i,
  input  logic [AddrWidth-1:0] waddr_i,
  output logic                 vrf_req_o,
  output logic                 vrf_we_o,
  output logic [AddrWidth-1:0] vrf_raddr_a_o,
  output logic [AddrWidth-1:0] vrf_raddr_b_o,
  output logic [AddrWidth-1:0] vrf_waddr_o,
  output logic [1:0]           vrf_num_ops_o,
  output logic [2:0]           vrf_lmul_o,
  input  logic                 vrf_done_i,
  output logic [31:0]          vl_o,
  output logic                 vill_o,
`ifdef VISSUE_PERF_CNT_EN
  output logic [31:0]          perf_busy_cyc_o,
  output logic [31:0]          perf_ops_o,
`endif
  output logic                 illegal_o,
  output logic                 stall_o
);

  typedef enum logic {IDLE, BUSY} state_e;

  localparam logic [31:0] COUNT = 32'(VLEN / ELEN);

  state_e               state_q;
  logic                 req_q, we_q, vill_q, illegal_q;
  logic [AddrWidth-1:0] raddr_a_q, raddr_b_q, waddr_q;
  logic [1:0]           ops_q;
  logic [2:0]           lmul_q;
  logic [31:0]          vl_q;

  logic [31:0]          vlmax_d, vl_d;
  logic                 vset_bad_d, misaligned_d, accept_d;
  logic [AddrWidth-1:0] grp_mask_d;

  always_comb begin
    vlmax_d = '0;
    case (vset_lmul_i)
      3'b000:  vlmax_d = COUNT;
      3'b001:  vlmax_d = COUNT << 1;
      3'b010:  vlmax_d = COUNT << 2;
      3'b011:  vlmax_d = COUNT << 3;
      3'b101:  vlmax_d = COUNT >> 3;
      3'b110:  vlmax_d = COUNT >> 2;
      3'b111:  vlmax_d = COUNT >> 1;
      default: vlmax_d = '0;
    endcase
    vset_bad_d = (vset_lmul_i == 3'b100) || (vlmax_d == '0);
    vl_d       = (vset_avl_i < vlmax_d) ? vset_avl_i : vlmax_d;

    // Register groups must start on a multiple of LMUL; fractional LMUL has no constraint.
    grp_mask_d = '0;
    case (lmul_q)
      3'b001:  grp_mask_d = AddrWidth'(1);
      3'b010:  grp_mask_d = AddrWidth'(3);
      3'b011:  grp_mask_d = AddrWidth'(7);
      default: grp_mask_d = '0;
    endcase
    misaligned_d = (we_i && |(waddr_i & grp_mask_d))
                || ((num_operands_i >= 2'd1) && |(raddr_a_i & grp_mask_d))
                || ((num_operands_i >= 2'd2) && |(raddr_b_i & grp_mask_d));
    accept_d = valid_i && (state_q == IDLE);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      raddr_a_q <= '0;
      raddr_b_q <= '0;
      waddr_q   <= '0;
      ops_q     <= '0;
      lmul_q    <= 3'b000;
      vl_q      <= '0;
      vill_q    <= 1'b1;
      illegal_q <= 1'b0;
    end else begin
      illegal_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept_d) begin
            if (is_vset_i) begin
              if (vset_bad_d) begin
                vill_q <= 1'b1;
                vl_q   <= '0;
              end else begin
                vill_q <= 1'b0;
                vl_q   <= vl_d;
                lmul_q <= vset_lmul_i;
              end
            end else if (vill_q || misaligned_d) begin
              illegal_q <= 1'b1;
            end else begin
              raddr_a_q <= raddr_a_i;
              raddr_b_q <= raddr_b_i;
              waddr_q   <= waddr_i;
              ops_q     <= num_operands_i;
              we_q      <= we_i;
              req_q     <= 1'b1;
              state_q   <= BUSY;
            end
          end
        end
        BUSY: begin
          // Req stays high across all group iterations; only done releases it.
          if (vrf_done_i) begin
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef VISSUE_PERF_CNT_EN
  logic [31:0] busy_cyc_q, ops_cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      busy_cyc_q <= '0;
      ops_cnt_q  <= '0;
    end else if (state_q == BUSY) begin
      busy_cyc_q <= busy_cyc_q + 32'd1;
      if (vrf_done_i) ops_cnt_q <= ops_cnt_q + 32'd1;
    end
  end

  assign perf_busy_cyc_o = busy_cyc_q;
  assign perf_ops_o      = ops_cnt_q;
`endif

  assign ready_o       = (state_q == IDLE);
  assign stall_o       = (state_q != IDLE);
  assign vrf_req_o     = req_q;
  assign vrf_we_o      = we_q;
  assign vrf_raddr_a_o = raddr_a_q;
  assign vrf_raddr_b_o = raddr_b_q;
  assign vrf_waddr_o   = waddr_q;
  assign vrf_num_ops_o = ops_q;
  assign vrf_lmul_o    = lmul_q;
  assign vl_o          = vl_q;
  assign vill_o        = vill_q;
  assign illegal_o     = illegal_q;

endmodule

// File: tb/tb_vissue_ctrl.sv
// Bench for vissue_ctrl: directed vset/op vectors, scoreboard of expected requests and rejections.
module tb_vissue_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid, is_vset, we, done;
  logic [2:0]  vset_lmul;
  logic [31:0] vset_avl;
  logic [1:0]  num_ops;
  logic [4:0]  raddr_a, raddr_b, waddr;
  logic        ready, req, vrf_we, vill, illegal, stall;
  logic [4:0]  vrf_ra, vrf_rb, vrf_wa;
  logic [1:0]  vrf_nops;
  logic [2:0]  vrf_lmul;
  logic [31:0] vl;
`ifdef VISSUE_PERF_CNT_EN
  logic [31:0] perf_busy, perf_ops;
`endif

  always #5 clk = ~clk;

  vissue_ctrl dut (
    .clk_i(clk), .rst_i(rst), .valid_i(valid), .ready_o(ready),
    .is_vset_i(is_vset), .vset_lmul_i(vset_lmul), .vset_avl_i(vset_avl),
    .num_operands_i(num_ops), .we_i(we), .raddr_a_i(raddr_a), .raddr_b_i(raddr_b),
    .waddr_i(waddr), .vrf_req_o(req), .vrf_we_o(vrf_we), .vrf_raddr_a_o(vrf_ra),
    .vrf_raddr_b_o(vrf_rb), .vrf_waddr_o(vrf_wa), .vrf_num_ops_o(vrf_nops),
    .vrf_lmul_o(vrf_lmul), .vrf_done_i(done), .vl_o(vl), .vill_o(vill),
`ifdef VISSUE_PERF_CNT_EN
    .perf_busy_cyc_o(perf_busy), .perf_ops_o(perf_ops),
`endif
    .illegal_o(illegal), .stall_o(stall)
  );

  typedef struct packed {
    logic       ill;
    logic [4:0] vd, vs1, vs2;
    logic [1:0] ops;
    logic       we;
    logic [2:0] lmul;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_err    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every rejection pulse and every rising request is matched against the scoreboard.
  logic req_prev = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      req_prev = 1'b0;
    end else begin
      if (illegal || (req && !req_prev)) begin
        if (sb.size() == 0) begin
          chk("sb_unexpected_event", 32'(illegal), 32'(!illegal));
        end else begin
          e = sb.pop_front();
          chk("sb_kind_illegal", 32'(illegal), 32'(e.ill));
          chk("sb_kind_req", 32'(req), 32'(!e.ill));
          if (!e.ill) begin
            chk("sb_waddr", 32'(vrf_wa), 32'(e.vd));
            chk("sb_raddr_a", 32'(vrf_ra), 32'(e.vs1));
            chk("sb_raddr_b", 32'(vrf_rb), 32'(e.vs2));
            chk("sb_num_ops", 32'(vrf_nops), 32'(e.ops));
            chk("sb_we", 32'(vrf_we), 32'(e.we));
            chk("sb_lmul", 32'(vrf_lmul), 32'(e.lmul));
          end
        end
      end
      req_prev = req;
    end
  end

  task automatic vset(input logic [2:0] lmul, input logic [31:0] avl,
                      input logic [31:0] exp_vl, input logic exp_vill, input logic [2:0] exp_lmul);
    @(negedge clk);
    valid = 1'b1; is_vset = 1'b1; vset_lmul = lmul; vset_avl = avl;
    @(posedge clk); #1;
    valid = 1'b0; is_vset = 1'b0;
    @(negedge clk);
    chk("vset_vl", vl, exp_vl);
    chk("vset_vill", 32'(vill), 32'(exp_vill));
    chk("vset_lmul", 32'(vrf_lmul), 32'(exp_lmul));
    chk("vset_ready", 32'(ready), 32'd1);
  endtask

  task automatic vop(input logic now, input logic [4:0] vd, input logic [4:0] vs1,
                     input logic [4:0] vs2, input logic [1:0] ops, input logic w,
                     input logic exp_ill, input logic [2:0] exp_lmul);
    sb.push_back('{ill: exp_ill, vd: vd, vs1: vs1, vs2: vs2, ops: ops, we: w, lmul: exp_lmul});
    if (!now) @(negedge clk);
    valid = 1'b1; is_vset = 1'b0; waddr = vd; raddr_a = vs1; raddr_b = vs2;
    num_ops = ops; we = w;
    @(posedge clk); #1;
    valid = 1'b0;
  endtask

  task automatic after_illegal();
    @(negedge clk);
    @(negedge clk);
    chk("illegal_one_cycle", 32'(illegal), 32'd0);
    chk("illegal_no_req", 32'(req), 32'd0);
    chk("illegal_ready", 32'(ready), 32'd1);
  endtask

  task automatic finish_op();
    @(negedge clk);
    done = 1'b1;
    @(posedge clk); #1;
    done = 1'b0;
    @(negedge clk);
    chk("done_req_low", 32'(req), 32'd0);
    chk("done_we_low", 32'(vrf_we), 32'd0);
    chk("done_ready", 32'(ready), 32'd1);
    chk("done_stall", 32'(stall), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; valid = 1'b0; is_vset = 1'b0; we = 1'b0; done = 1'b0;
    vset_lmul = '0; vset_avl = '0; num_ops = '0; raddr_a = '0; raddr_b = '0; waddr = '0;
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_req", 32'(req), 32'd0);
    chk("rst_we", 32'(vrf_we), 32'd0);
    chk("rst_addrs", {17'd0, vrf_ra, vrf_rb, vrf_wa}, 32'd0);
    chk("rst_nops", 32'(vrf_nops), 32'd0);
    chk("rst_lmul", 32'(vrf_lmul), 32'd0);
    chk("rst_vl", vl, 32'd0);
    chk("rst_vill", 32'(vill), 32'd1);
    chk("rst_illegal", 32'(illegal), 32'd0);
    rst = 1'b0;

    // vill set out of reset: any op rejected
    vop(1'b0, 5'd2, 5'd2, 5'd2, 2'd1, 1'b1, 1'b1, 3'b000);
    after_illegal();

    vset(3'b001, 32'd5, 32'd5, 1'b0, 3'b001);
    vset(3'b010, 32'd20, 32'd16, 1'b0, 3'b010);

    // LMUL_4 op held across four group iterations; vset and done-free cycles ignored
    vop(1'b0, 5'd4, 5'd8, 5'd12, 2'd2, 1'b1, 1'b0, 3'b010);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("busy_req", 32'(req), 32'd1);
      chk("busy_ready", 32'(ready), 32'd0);
      chk("busy_stall", 32'(stall), 32'd1);
      chk("busy_waddr", 32'(vrf_wa), 32'd4);
      chk("busy_raddr_a", 32'(vrf_ra), 32'd8);
      if (i == 1) begin
        valid = 1'b1; is_vset = 1'b1; vset_lmul = 3'b000; vset_avl = 32'd1;
        raddr_a = 5'd1; waddr = 5'd3;
      end else begin
        valid = 1'b0; is_vset = 1'b0;
      end
    end
    chk("busy_vset_ignored_vl", vl, 32'd16);
    chk("busy_vset_ignored_lmul", 32'(vrf_lmul), 32'd2);
    finish_op();

    // back-to-back: issue in the very cycle ready returns
    vop(1'b1, 5'd0, 5'd4, 5'd0, 2'd1, 1'b0, 1'b0, 3'b010);
    finish_op();

    // spurious done while idle
    @(negedge clk);
    done = 1'b1;
    @(posedge clk); #1;
    done = 1'b0;
    @(negedge clk);
    chk("spurious_done_ready", 32'(ready), 32'd1);
    chk("spurious_done_req", 32'(req), 32'd0);
    chk("spurious_done_raddr", 32'(vrf_ra), 32'd4);

    vset(3'b001, 32'd100, 32'd8, 1'b0, 3'b001);
    vop(1'b0, 5'd1, 5'd3, 5'd0, 2'd1, 1'b0, 1'b1, 3'b001);
    after_illegal();
    // odd vd/vs2 allowed when not used
    vop(1'b0, 5'd1, 5'd2, 5'd5, 2'd1, 1'b0, 1'b0, 3'b001);
    finish_op();
    vop(1'b0, 5'd6, 5'd2, 5'd5, 2'd2, 1'b1, 1'b1, 3'b001);
    after_illegal();

    vset(3'b100, 32'd4, 32'd0, 1'b1, 3'b001);
    vset(3'b001, 32'd3, 32'd3, 1'b0, 3'b001);
    vset(3'b101, 32'd3, 32'd0, 1'b1, 3'b001);
    vop(1'b0, 5'd2, 5'd4, 5'd6, 2'd2, 1'b1, 1'b1, 3'b001);
    after_illegal();

    vset(3'b111, 32'd7, 32'd2, 1'b0, 3'b111);
    vset(3'b110, 32'd7, 32'd1, 1'b0, 3'b110);
    vop(1'b0, 5'd3, 5'd5, 5'd7, 2'd3, 1'b1, 1'b0, 3'b110);
    @(negedge clk);
    chk("pre_rst_req", 32'(req), 32'd1);
`ifdef VISSUE_PERF_CNT_EN
    chk("perf_ops_count", perf_ops, 32'd3);
`endif
    #2 rst = 1'b1;
    #1;
    chk("rst_async_req", 32'(req), 32'd0);
    chk("rst_async_ready", 32'(ready), 32'd1);
    chk("rst_async_vill", 32'(vill), 32'd1);
    chk("rst_async_vl", vl, 32'd0);
`ifdef VISSUE_PERF_CNT_EN
    chk("rst_perf_busy", perf_busy, 32'd0);
    chk("rst_perf_ops", perf_ops, 32'd0);
`endif
    @(negedge clk);
    rst = 1'b0;

    vset(3'b011, 32'd40, 32'd32, 1'b0, 3'b011);
    vset(3'b000, 32'd2, 32'd2, 1'b0, 3'b000);

    @(negedge clk);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
